// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// Defines package imem_ctrl_pkg: FSM state enum, BRAM geometry, fault mask, length clamp.
package imem_ctrl_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_LEN_W  = 11;

    // Any set bit here means the fetch address lies outside the 4 KiB image.
    localparam logic [31:0] IMEM_FAULT_MASK = 32'hFFFF_F000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } imem_state_e;

    function automatic logic [IMEM_LEN_W-1:0] clamp_len(input logic [IMEM_LEN_W-1:0] len);
        return (len > IMEM_LEN_W'(IMEM_DEPTH)) ? IMEM_LEN_W'(IMEM_DEPTH) : len;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of fetch, loader and BRAM signals around the instruction-memory load controller.
// Handshakes: a transfer happens on a rising edge where both the request/valid and ready are 1.
interface imem_load_ctrl_if;
    import imem_ctrl_pkg::*;

    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [31:0]           fetch_instr;
    logic                  fetch_fault;

    logic                  load_start;
    logic [IMEM_LEN_W-1:0] load_len;
    logic                  ld_byte_valid;
    logic                  ld_byte_ready;
    logic [7:0]            ld_byte;
    logic                  busy;
    logic                  load_done;
    logic [31:0]           load_checksum;

    logic                   bram_we;
    logic [IMEM_ADDR_W-1:0] bram_addr;
    logic [31:0]            bram_wdata;
    logic [31:0]            bram_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_len, ld_byte_valid, ld_byte, bram_rdata,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, ld_byte_ready, busy,
               load_done, load_checksum, bram_we, bram_addr, bram_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_start, load_len, ld_byte_valid, ld_byte, bram_rdata,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, ld_byte_ready, busy,
               load_done, load_checksum, bram_we, bram_addr, bram_wdata
    );

endinterface

// File: rtl/imem_load_ctrl_packer.sv
// imem_byte_packer: accepts loader bytes and assembles them little-endian into a 32-bit word.
// word_ready_o strobes in the cycle the fourth byte of a word is accepted.
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        accept;

    assign byte_ready_o = enable_i && !rst;
    assign accept       = byte_valid_i && byte_ready_o;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (accept) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = accept && (idx_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction BRAM between fetch reads and a byte-stream program loader.
// Optional IMEM_LOAD_CHECKSUM_EN: load_checksum sums every written word (else tied to 0).
module imem_load_ctrl
    import imem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    imem_load_ctrl_if.slave   bus,
    output imem_state_e       dbg_state_o
);

    imem_state_e           state_q, state_d;
    logic [IMEM_LEN_W-1:0] len_q, len_d, word_cnt_q, word_cnt_d, len_in, word_cnt_inc;
    logic                  load_acc, fetch_acc, last_word, word_ready, load_done_d;
    logic                  fetch_valid_q, fetch_fault_q, load_done_q;
    logic [31:0]           packed_word;

    assign len_in       = clamp_len(bus.load_len);
    assign load_acc     = (state_q == IDLE) && bus.load_start && !rst;
    assign fetch_acc    = bus.fetch_req && bus.fetch_ready;
    assign word_cnt_inc = word_cnt_q + IMEM_LEN_W'(1);
    assign last_word    = (word_cnt_inc == len_q);

    imem_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (load_acc),
        .enable_i     (state_q == COLLECT),
        .byte_valid_i (bus.ld_byte_valid),
        .byte_i       (bus.ld_byte),
        .byte_ready_o (bus.ld_byte_ready),
        .word_o       (packed_word),
        .word_ready_o (word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_acc && (len_in != '0)) state_d = COLLECT;
            COLLECT: if (word_ready) state_d = WRITE;
            WRITE:   state_d = last_word ? IDLE : COLLECT;
            default: state_d = IDLE;
        endcase
    end

    // A load command in the same cycle as a fetch request wins the BRAM port.
    always_comb begin
        bus.fetch_ready = (state_q == IDLE) && !bus.load_start && !rst;
        bus.busy        = (state_q != IDLE);
        bus.bram_we     = (state_q == WRITE);
        bus.bram_wdata  = packed_word;
        bus.bram_addr   = (state_q == IDLE) ? bus.fetch_addr[11:2]
                                            : word_cnt_q[IMEM_ADDR_W-1:0];
    end

    always_comb begin
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        load_done_d = (load_acc && (len_in == '0)) || ((state_q == WRITE) && last_word);
        if (load_acc) begin
            len_d      = len_in;
            word_cnt_d = '0;
        end else if (state_q == WRITE) begin
            word_cnt_d = word_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q         <= '0;
            word_cnt_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            len_q         <= len_d;
            word_cnt_q    <= word_cnt_d;
            fetch_valid_q <= fetch_acc;
            fetch_fault_q <= fetch_acc && ((bus.fetch_addr & IMEM_FAULT_MASK) != 32'h0);
            load_done_q   <= load_done_d;
        end
    end

    // The BRAM output register supplies the data; a faulting fetch reads back as zero.
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fetch_instr = (fetch_valid_q && !fetch_fault_q) ? bus.bram_rdata : 32'h0;
    assign bus.load_done   = load_done_q;
    assign dbg_state_o     = state_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load_acc)               csum_d = 32'h0;
        else if (state_q == WRITE)  csum_d = csum_q + packed_word;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= 32'h0;
        else     csum_q <= csum_d;
    end

    assign bus.load_checksum = csum_q;
`else
    assign bus.load_checksum = 32'h0;
`endif

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that sequences and shares the 1024×32 instruction BRAM between the CPU fetch stage and a byte-stream program loader (UART/debug). While idle it serves single-cycle-issue fetch reads. On a load command it stalls fetch, packs incoming bytes into little-endian words, and writes them to consecutive BRAM addresses. It sits between the fetch stage, the loader front-end and the instruction BRAM.

## Interface
- DEPTH, 1024: BRAM words; address width is fixed at 10.
- MAX_LEN_W, 11: width of `load_len`.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; accepted when `fetch_ready`=1.
- fetch_addr  in  32  byte address; bits [1:0] are ignored.
- fetch_ready  out  1  high when the controller can accept a fetch.
- fetch_valid  out  1  `fetch_instr` is valid this cycle.
- fetch_instr  out  32  instruction word.
- fetch_fault  out  1  accepted fetch had `fetch_addr[31:12]` ≠ 0.
- load_start  in  1  one-cycle command to begin a load.
- load_len  in  11  number of words to load; sampled on `load_start`.
- ld_byte_valid / ld_byte_ready  in / out  1  loader byte handshake.
- ld_byte  in  8  loader byte; least-significant byte first.
- busy  out  1  high in COLLECT and WRITE.
- load_done  out  1  one-cycle pulse when the load completes.
- load_checksum  out  32  see Configuration.
- bram_we  out  1; bram_addr  out  10; bram_wdata  out  32; bram_rdata  in  32 (registered BRAM output, 1-cycle read latency).

## Operation
- States:
  - IDLE: fetch served.
  - COLLECT: accepting bytes.
  - WRITE: one cycle, `bram_we`=1.
- IDLE:
  - `fetch_ready` = !`load_start`.
  - An accepted fetch drives `bram_addr` = `fetch_addr[11:2]`.
- `load_start` in IDLE:
  - Latch `len` = min(`load_len`, 1024).
  - Clear `word_cnt` and the byte index.
  - Go to COLLECT.
  - If `len`=0, stay in IDLE and pulse `load_done` next cycle.
- `load_start` outside IDLE is ignored.
- COLLECT:
  - `ld_byte_ready`=1.
  - Each accepted byte fills lane `idx` (0..3).
  - The 4th accepted byte goes to WRITE.
- WRITE:
  - `bram_we`=1, `bram_addr`=`word_cnt[9:0]`, `bram_wdata`=packed word.
  - `word_cnt`++.
  - If `word_cnt`+1 = `len`, go to IDLE and pulse `load_done` in the following cycle; otherwise go to COLLECT.
- Any fetch request while not in IDLE is held off (`fetch_ready`=0). The controller never drops or reorders an accepted fetch.
- Reset mid-load:
  - Return to IDLE; the partial word and counts are discarded.
  - BRAM contents are not touched. Words already written remain.

## Timing
- Reset values (registered): state=IDLE, `fetch_valid`=0, `fetch_fault`=0, `fetch_instr`=0, `load_done`=0, `bram_we`=0, `word_cnt`=0, `load_checksum`=0.
- `fetch_ready` and `ld_byte_ready` are 0 while `rst`=1.
- Fetch accepted in cycle N → `fetch_valid`=1 with `fetch_instr`=`bram_rdata` in N+1.
- `fetch_fault` is asserted alongside `fetch_valid` in N+1 when applicable; `fetch_instr` is then 0.
- Back-to-back fetches run at one per cycle.
- `load_start` and `fetch_req` in the same cycle: the load wins, and no fetch is accepted in that cycle.
- The cycle after the final WRITE is IDLE; fetches can be accepted there, in the same cycle as the `load_done` pulse.
- Throughput: 4 bytes per 5 cycles minimum. `ld_byte_ready`=0 during WRITE.
- `bram_we` is never high in IDLE. `bram_addr` is a mux of fetch and load addresses selected by state.

## Configuration
- `IMEM_LOAD_CHECKSUM_EN` defined:
  - `load_checksum` accumulates the mod-2^32 sum of every written word.
  - It clears on accepted `load_start`.
  - It is stable from the `load_done` pulse onward.
- Undefined: `load_checksum` is tied to 0 and no adder is synthesized.

## Structure
- Package `imem_ctrl_pkg`:
  - state enum (IDLE, COLLECT, WRITE).
  - `IMEM_DEPTH`=1024, `IMEM_ADDR_W`=10.
  - `IMEM_FAULT_MASK` (bits [31:12]).
- One sub-module, `imem_byte_packer`: byte handshake, lane index, 32-bit assembly, `word_ready` strobe.
- The FSM, arbitration mux, counters and checksum live in the top level.

## Test plan
- Reset, then `fetch_req` with `fetch_addr`=0x8, BRAM word2=0xDEADBEEF → `fetch_valid`=1 and `fetch_instr`=0xDEADBEEF one cycle later.
- `load_start`, `load_len`=2, bytes 11 22 33 44 55 66 77 88 → BRAM[0]=0x44332211, BRAM[1]=0x88776655, one `load_done` pulse, checksum 0xCCAA8866 when `IMEM_LOAD_CHECKSUM_EN` is defined.
- `fetch_req` held high during a load → `fetch_ready`=0 throughout; the first fetch is accepted in the cycle of `load_done`.
- `load_len`=0 → no `bram_we`, `load_done` pulse one cycle later, `busy` stays 0.
- `fetch_addr`=0x0000_1000 → `fetch_fault`=1, `fetch_instr`=0.
- `rst` asserted after 5 bytes of a 3-word load → IDLE, BRAM[0] written, BRAM[1] unchanged, no `load_done`.
